vault_lock_ctrl: RTL

- Sequencing FSM for the bank vault lock.
- Accepts keypad digits, compares the entered code against a stored code, and drives the 2-bit status word used by the seven-segment word display (LOCK / OPEN / ERR).
- Handles error indication, lockout after repeated failures, auto-relock, and changing the code while open.

---
 rtl/vault_pkg.sv | 21 ++
 rtl/vault_timer.sv | 26 ++
 rtl/vault_lock_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vault_pkg.sv
// Shared encodings for the vault lock controller and the seven-segment word display.
package vault_pkg;

    localparam logic [1:0] ST_LOCK = 2'b11;
    localparam logic [1:0] ST_OPEN = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;

    typedef enum logic [1:0] {
        LOCKED,
        OPEN,
        ERR,
        LOCKOUT
    } state_e;

    typedef logic [3:0] bcd_t;

    function automatic logic is_bcd(bcd_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/vault_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module vault_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/vault_lock_ctrl.sv
// Vault lock sequencer: keypad code entry, ERR/lockout handling, auto-relock, code change.
module vault_lock_ctrl
    import vault_pkg::*;
#(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [31:0] RESET_CODE     = 32'h0000_1234,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned ERR_CYCLES     = 50_000_000,
    parameter int unsigned OPEN_CYCLES    = 500_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       lock_btn,
    input  logic       set_code,
    output logic [1:0] status,
    output logic       unlocked,
    output logic       lockout,
    output logic [3:0] fail_count,
    output logic [3:0] digit_count
);

    localparam int unsigned CW   = CODE_LEN * 4;
    localparam int unsigned MAXC = (LOCKOUT_CYCLES > OPEN_CYCLES)
                                 ? ((LOCKOUT_CYCLES > ERR_CYCLES) ? LOCKOUT_CYCLES : ERR_CYCLES)
                                 : ((OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES);
    localparam int unsigned TW   = $clog2(MAXC) + 1;

    localparam logic [3:0] LEN4 = 4'(CODE_LEN);
    localparam logic [3:0] SAT4 = 4'(CODE_LEN + 1);
    localparam logic [3:0] MAX4 = 4'(MAX_TRIES);

    // Timer holds N-1 so the state lasts exactly N cycles before done is seen.
    localparam logic [TW-1:0] T_ERR  = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] T_LKO  = TW'(LOCKOUT_CYCLES - 1);

    state_e        state_q;
    logic [1:0]    status_q;
    logic          unlocked_q;
    logic          lockout_q;
    logic [3:0]    fail_q;
    logic [3:0]    dcnt_q;
    logic [CW-1:0] entry_q;
    logic [CW-1:0] code_q;
    logic          bad_q;

    logic          entry_ok;
    logic          match;
    logic [3:0]    fail_nxt;
    logic [CW-1:0] entry_shift;
    logic [3:0]    dcnt_inc;
    logic          bad_nxt;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    assign entry_ok    = (dcnt_q == LEN4) && !bad_q;
    assign match       = entry_ok && (entry_q == code_q);
    assign fail_nxt    = fail_q + 4'd1;
    assign entry_shift = (entry_q << 4) | CW'(digit);
    assign dcnt_inc    = (dcnt_q == SAT4) ? dcnt_q : dcnt_q + 4'd1;
    assign bad_nxt     = bad_q || !is_bcd(digit);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            LOCKED: begin
                if (enter) begin
                    tmr_load = 1'b1;
                    if (match)                 tmr_val = T_OPEN;
                    else if (fail_nxt == MAX4) tmr_val = T_LKO;
                    else                       tmr_val = T_ERR;
                end
            end
            OPEN: begin
                if (!lock_btn && !tmr_done && set_code && entry_ok) begin
                    tmr_load = 1'b1;
                    tmr_val  = T_OPEN;
                end
            end
            default: ;
        endcase
    end

    vault_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOCKED;
            status_q   <= ST_LOCK;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            fail_q     <= '0;
            dcnt_q     <= '0;
            entry_q    <= '0;
            bad_q      <= 1'b0;
            code_q     <= RESET_CODE[CW-1:0];
        end else begin
            case (state_q)
                LOCKED: begin
                    if (enter) begin
                        entry_q <= '0;
                        dcnt_q  <= '0;
                        bad_q   <= 1'b0;
                        if (match) begin
                            state_q    <= OPEN;
                            status_q   <= ST_OPEN;
                            unlocked_q <= 1'b1;
                            fail_q     <= '0;
                        end else begin
                            fail_q   <= fail_nxt;
                            status_q <= ST_ERR;
                            if (fail_nxt == MAX4) begin
                                state_q   <= LOCKOUT;
                                lockout_q <= 1'b1;
                            end else begin
                                state_q <= ERR;
                            end
                        end
                    end else if (digit_valid) begin
                        entry_q <= entry_shift;
                        dcnt_q  <= dcnt_inc;
                        bad_q   <= bad_nxt;
                    end
                end
                OPEN: begin
                    if (lock_btn || tmr_done) begin
                        state_q    <= LOCKED;
                        status_q   <= ST_LOCK;
                        unlocked_q <= 1'b0;
                        entry_q    <= '0;
                        dcnt_q     <= '0;
                        bad_q      <= 1'b0;
                    end else if (set_code) begin
                        if (entry_ok) code_q <= entry_q;
                    end else if (enter) begin
                        entry_q <= '0;
                        dcnt_q  <= '0;
                        bad_q   <= 1'b0;
                    end else if (digit_valid) begin
                        entry_q <= entry_shift;
                        dcnt_q  <= dcnt_inc;
                        bad_q   <= bad_nxt;
                    end
                end
                ERR: begin
                    if (tmr_done) begin
                        state_q  <= LOCKED;
                        status_q <= ST_LOCK;
                    end
                end
                LOCKOUT: begin
                    if (tmr_done) begin
                        state_q   <= LOCKED;
                        status_q  <= ST_LOCK;
                        lockout_q <= 1'b0;
                        fail_q    <= '0;
                    end
                end
                default: state_q <= LOCKED;
            endcase
        end
    end

    assign status      = status_q;
    assign unlocked    = unlocked_q;
    assign lockout     = lockout_q;
    assign fail_count  = fail_q;
    assign digit_count = dcnt_q;

endmodule
